amber48_uart_rx: RTL

- UART receiver for the amber48 FPGA top. It takes the board rxp pin and deserialises 8N1 frames.
- Received bytes are buffered in a small FIFO and offered to the dmem MMIO UART block through a valid/ready pop interface.
- It is the counterpart to amber48_uart_tx and uses the same baud parameters.

---
 rtl/amber48_uart_rx_if.sv | 9 +
 rtl/amber48_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/amber48_uart_rx_if.sv
// Valid/ready pop channel between the UART receive FIFO and its MMIO consumer.
interface amber48_uart_rx_if;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i;

    modport master (output data_o, output valid_o, input ready_i);
    modport slave  (input data_o, input valid_o, output ready_i);
endinterface

// File: rtl/amber48_uart_rx.sv
// amber48 UART receiver: 2-flop synchroniser, 8N1 deserialiser FSM and a small pop FIFO.
// Define AMBER48_UART_RX_PARITY_EN to add an even-parity bit and the parity_err_o flag.
module amber48_uart_rx #(
    parameter int unsigned CLOCK_FREQ_HZ = 27_000_000,
    parameter int unsigned BAUD_RATE     = 115_200,
    parameter int unsigned FIFO_DEPTH    = 4
) (
    input  logic               sys_clk,
    input  logic               rst_sync_n,
    input  logic               rx_i,
    amber48_uart_rx_if.master  pop,
    output logic               frame_err_o,
    output logic               overrun_o,
`ifdef AMBER48_UART_RX_PARITY_EN
    output logic               parity_err_o,
`endif
    input  logic               err_clr_i,
    output logic               busy_o
);

    localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
    localparam int unsigned PTR_W        = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W        = PTR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef AMBER48_UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BRK_WAIT
    } state_e;

    state_e             state_q, state_n;
    logic [1:0]         sync_q;
    logic               rx_s;
    logic [CNT_W-1:0]   cnt_q;
    logic [2:0]         bit_idx_q;
    logic [7:0]         shift_q;
    logic               tick_c;
    logic               cnt_clr_c, bit_clr_c, shift_c, push_req_c, ferr_set_c;
    logic               busy_q, frame_err_q, overrun_q;

    logic [7:0]         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]   occ_q, occ_n;
    logic [7:0]         data_q, data_n;
    logic               valid_q;
    logic               pop_c, full_c, push_c, ovr_set_c;

`ifdef AMBER48_UART_RX_PARITY_EN
    logic               par_bad_q, perr_set_c, parity_err_q;
`endif

    assign rx_s   = sync_q[1];
    assign tick_c = (state_q == S_START) ? (cnt_q == CNT_W'(HALF_BIT - 1))
                                         : (cnt_q == CNT_W'(CLKS_PER_BIT - 1));

    // Line synchroniser; resets to the idle-high level.
    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) sync_q <= 2'b11;
        else             sync_q <= {sync_q[0], rx_i};
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) state_q <= S_IDLE;
        else             state_q <= state_n;
    end

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        case (state_q)
            S_IDLE:     if (!rx_s) state_n = S_START;
            S_START:    if (tick_c) state_n = rx_s ? S_IDLE : S_DATA;
`ifdef AMBER48_UART_RX_PARITY_EN
            S_DATA:     if (tick_c && bit_idx_q == 3'd7) state_n = S_PARITY;
            S_PARITY:   if (tick_c) state_n = S_STOP;
`else
            S_DATA:     if (tick_c && bit_idx_q == 3'd7) state_n = S_STOP;
`endif
            S_STOP:     if (tick_c) state_n = rx_s ? S_IDLE : S_BRK_WAIT;
            S_BRK_WAIT: if (rx_s) state_n = S_IDLE;
            default:    state_n = S_IDLE;
        endcase
    end

    // Per-state datapath controls.
    always_comb begin
        cnt_clr_c  = 1'b0;
        bit_clr_c  = 1'b0;
        shift_c    = 1'b0;
        push_req_c = 1'b0;
        ferr_set_c = 1'b0;
`ifdef AMBER48_UART_RX_PARITY_EN
        perr_set_c = 1'b0;
`endif
        case (state_q)
            S_IDLE:     cnt_clr_c = 1'b1;
            S_START: begin
                cnt_clr_c = tick_c;
                bit_clr_c = tick_c;
            end
            S_DATA: begin
                cnt_clr_c = tick_c;
                shift_c   = tick_c;
            end
`ifdef AMBER48_UART_RX_PARITY_EN
            S_PARITY: begin
                cnt_clr_c  = tick_c;
                perr_set_c = tick_c && (^{shift_q, rx_s});
            end
            S_STOP: begin
                cnt_clr_c  = tick_c;
                push_req_c = tick_c && rx_s && !par_bad_q;
                ferr_set_c = tick_c && !rx_s;
            end
`else
            S_STOP: begin
                cnt_clr_c  = tick_c;
                push_req_c = tick_c && rx_s;
                ferr_set_c = tick_c && !rx_s;
            end
`endif
            S_BRK_WAIT: cnt_clr_c = 1'b1;
            default:    cnt_clr_c = 1'b1;
        endcase
    end

    // Shared bit-timing counter, bit index and LSB-first shift register.
    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            cnt_q <= cnt_clr_c ? '0 : cnt_q + CNT_W'(1);
            if (bit_clr_c)    bit_idx_q <= '0;
            else if (shift_c) bit_idx_q <= bit_idx_q + 3'd1;
            if (shift_c)      shift_q   <= {rx_s, shift_q[7:1]};
        end
    end

    // FIFO push/pop decisions; a pop frees the slot a full-FIFO push needs.
    assign pop_c     = valid_q && pop.ready_i;
    assign full_c    = (occ_q == OCC_W'(FIFO_DEPTH));
    assign push_c    = push_req_c && (!full_c || pop_c);
    assign ovr_set_c = push_req_c && full_c && !pop_c;

    always_comb begin
        occ_n = occ_q + OCC_W'(push_c) - OCC_W'(pop_c);
        data_n = data_q;
        if (pop_c && occ_q > OCC_W'(1))
            data_n = mem_q[rd_ptr_q + PTR_W'(1)];
        else if (push_c && (occ_q == '0 || pop_c))
            data_n = shift_q;
    end

    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= shift_q;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            occ_q   <= occ_n;
            data_q  <= data_n;
            valid_q <= (occ_n != '0);
        end
    end

    // Sticky flags: a set in the same cycle as a clear wins.
    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= ferr_set_c | (frame_err_q & ~err_clr_i);
            overrun_q   <= ovr_set_c  | (overrun_q & ~err_clr_i);
            busy_q      <= (state_n != S_IDLE);
        end
    end

`ifdef AMBER48_UART_RX_PARITY_EN
    always_ff @(posedge sys_clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            if (state_q == S_PARITY && tick_c) par_bad_q <= ^{shift_q, rx_s};
            parity_err_q <= perr_set_c | (parity_err_q & ~err_clr_i);
        end
    end

    assign parity_err_o = parity_err_q;
`endif

    assign pop.data_o  = data_q;
    assign pop.valid_o = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;
    assign busy_o      = busy_q;

endmodule
